// File: rtl/adder_slice_seq.sv
// rtl/adder_slice_seq.sv - multi-cycle WIDTH-bit adder reusing one SLICE-bit adder slice
// Optional macro ADDER_SLICE_SEQ_COUT_EN adds a registered carry-out port (cout).
module adder_slice_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             busy
`ifdef ADDER_SLICE_SEQ_COUT_EN
  ,
  output logic             cout
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] s_sl;
  logic             c_sl;
  logic             accept;
  logic             last_step;

  // The single shared slice adder, steered by the current slice index
  always_comb begin
    a_sl = a_q[idx_q*SLICE +: SLICE];
    b_sl = b_q[idx_q*SLICE +: SLICE];
    {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
  end

  assign accept    = in_valid && (state == IDLE);
  assign last_step = (idx_q == LAST_IDX);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        sum_q   <= '0;
        carry_q <= 1'b0;
        idx_q   <= '0;
      end else if (state == RUN) begin
        sum_q[idx_q*SLICE +: SLICE] <= s_sl;
        carry_q                     <= c_sl;
        // Index parks on the last slice so the part-select stays in range in DONE
        if (!last_step) idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign sum = sum_q;

`ifdef ADDER_SLICE_SEQ_COUT_EN
  logic cout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cout_q <= 1'b0;
    end else if (accept) begin
      cout_q <= 1'b0;
    end else if ((state == RUN) && last_step) begin
      cout_q <= c_sl;
    end
  end

  assign cout = cout_q;
`endif

endmodule

// File: tb/tb_adder_slice_seq.sv
// tb/tb_adder_slice_seq.sv - self-checking bench for adder_slice_seq (ADDER_SLICE_SEQ_COUT_EN aware)
module tb_adder_slice_seq;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             busy;
`ifdef ADDER_SLICE_SEQ_COUT_EN
  logic             cout;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adder_slice_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .busy     (busy)
`ifdef ADDER_SLICE_SEQ_COUT_EN
    ,
    .cout     (cout)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_sum;
    logic        exp_cout;
    int          hold;
    bit          noise;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain wide unsigned addition, carry is bit WIDTH
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic do_add(input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] exp_sum, input logic exp_cout,
                        input int hold, input bit noise);
    logic [WIDTH-1:0] held;
    int edges;
    bit seen;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    if (!noise) in_valid = 1'b0;
    check("busy_run", busy, 1);
    edges = 1;
    seen = 0;
    while (edges <= 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      check("in_ready_busy", in_ready, 0);
      if (out_valid) begin
        seen = 1;
        break;
      end
      if (noise) begin
        a = $urandom;
        b = $urandom;
        in_valid = 1'b1;
      end
    end
    check("latency_edges", edges, NSLICE + 1);
    if (!seen) begin
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b0;
    check("sum", sum, exp_sum);
`ifdef ADDER_SLICE_SEQ_COUT_EN
    check("cout", cout, exp_cout);
`endif
    held = sum;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_sum_stable", sum, held);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("after_out_valid", out_valid, 0);
    check("after_in_ready", in_ready, 1);
    check("after_busy", busy, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[8];
    logic [WIDTH:0] full;
    logic [31:0] ra;
    logic [31:0] rb;
    bit rose;

    tbl[0] = '{32'h0000_1234, 32'h0000_4321, 32'h0000_5555, 1'b0, 0, 1'b0};
    tbl[1] = '{32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000, 1'b0, 0, 1'b0};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 0, 1'b0};
    tbl[3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0, 1'b0};
    tbl[4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 0, 1'b0};
    tbl[5] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 6, 1'b0};
    tbl[6] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 1'b0, 0, 1'b1};
    tbl[7] = '{32'hAAAA_5555, 32'h5555_AAAA, 32'hFFFF_FFFF, 1'b0, 0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
`ifdef ADDER_SLICE_SEQ_COUT_EN
    check("rst_cout", cout, 0);
`endif

    for (int i = 0; i < 8; i++)
      do_add(tbl[i].a, tbl[i].b, tbl[i].exp_sum, tbl[i].exp_cout, tbl[i].hold, tbl[i].noise);

    // Reset at the second RUN edge discards the operation
    @(negedge clk);
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    rose = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) rose = 1;
    end
    check("midrst_no_result", rose, 0);
    do_add(32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) rb = ~ra + 32'($urandom_range(0, 2));
      full = ref_add(ra, rb);
      do_add(ra, rb, full[WIDTH-1:0], full[WIDTH], $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
